// File: rtl/inst_fetch.sv
// Instruction fetch: IDLE/REQ/WAIT/HOLD, one request in flight, timeout re-request; optional FETCH_MISALIGN_CHK_EN.
// Latency: request to next request >= 3 cycles; HOLD stalls with inst_o/pc_o stable until inst_ready_i.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        pc_sel_i,
  input  logic [31:0] alu_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        fetch_err_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, inst, next_pc;
  logic [7:0]  cnt, cnt_inc;
  logic        capture, timeout, accept, err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    timeout   = 1'b0;
    accept    = 1'b0;
    cnt_inc   = cnt + 8'd1;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (imem_rvalid_i) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          timeout   = 1'b1;
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (inst_ready_i) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign next_pc = pc_sel_i ? {alu_target_i[31:2], 2'b00} : pc + 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc   <= {RESET_PC[31:2], 2'b00};
      inst <= NOP;
      cnt  <= 8'd0;
      err  <= 1'b0;
    end else begin
      err <= timeout;
      if (state == REQ)                         cnt <= 8'd0;
      else if (state == WAIT && !imem_rvalid_i) cnt <= cnt_inc;
      if (capture) inst <= imem_rdata_i;
      if (accept)  pc   <= next_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misalign <= 1'b0;
    else         misalign <= accept && pc_sel_i && (alu_target_i[1:0] != 2'b00);
  end
  assign misalign_o = misalign;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^alu_target_i[1:0];
  assign misalign_o     = 1'b0;
`endif

  assign imem_req_o   = (state == REQ);
  assign imem_addr_o  = pc;
  assign inst_o       = inst;
  assign inst_valid_o = (state == HOLD);
  assign pc_o         = pc;
  assign pc_four_o    = pc + 32'd4;
  assign fetch_err_o  = err;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: transaction-level model checked every cycle plus literal spot checks.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0, inst_valid, inst_ready = 1'b0, pc_sel = 1'b0;
  logic        fetch_err, misalign;
  logic [31:0] imem_addr, imem_rdata = 32'h0, inst, alu_target = 32'h0, pc, pc_four;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_o(inst), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .pc_sel_i(pc_sel), .alu_target_i(alu_target),
    .pc_o(pc), .pc_four_o(pc_four),
    .fetch_err_o(fetch_err), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: tracks what the fetch unit owes (a request, an outstanding read, a held instruction).
  logic [31:0] m_pc = RST_PC, m_inst = NOP;
  bit          m_after_rst = 1'b1, m_req = 1'b0, m_out = 1'b0, m_held = 1'b0;
  bit          m_err = 1'b0, m_mis = 1'b0;
  int          m_miss = 0;

  always @(posedge clk or negedge rst_n) begin
    bit nreq, nerr, nmis;
    if (!rst_n) begin
      m_pc = RST_PC; m_inst = NOP; m_after_rst = 1'b1; m_req = 1'b0;
      m_out = 1'b0; m_held = 1'b0; m_err = 1'b0; m_mis = 1'b0; m_miss = 0;
    end else begin
      nreq = 1'b0; nerr = 1'b0; nmis = 1'b0;
      if (m_after_rst) begin
        m_after_rst = 1'b0; nreq = 1'b1;
      end else if (m_req) begin
        m_out = 1'b1; m_miss = 0;
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_inst = imem_rdata; m_held = 1'b1; m_out = 1'b0;
        end else begin
          m_miss++;
          if (m_miss == TMO) begin nerr = 1'b1; nreq = 1'b1; m_out = 1'b0; end
        end
      end else if (m_held && inst_ready) begin
        nmis   = MIS_EN && pc_sel && (alu_target % 4 != 0);
        m_pc   = pc_sel ? alu_target - (alu_target % 4) : m_pc + 32'd4;
        m_held = 1'b0; nreq = 1'b1;
      end
      m_req = nreq; m_err = nerr; m_mis = nmis;
    end
  end

  always @(negedge clk) begin
    chk("req",       {31'd0, imem_req},   {31'd0, m_req});
    chk("addr",      imem_addr,           m_pc);
    chk("pc",        pc,                  m_pc);
    chk("pc_four",   pc_four,             m_pc + 32'd4);
    chk("valid",     {31'd0, inst_valid}, {31'd0, m_held});
    chk("inst",      inst,                m_inst);
    chk("fetch_err", {31'd0, fetch_err},  {31'd0, m_err});
    chk("misalign",  {31'd0, misalign},   {31'd0, m_mis});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // First fetch: rvalid during REQ is ignored, real data arrives in WAIT.
    rst_n = 1'b1;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("first_inst", inst, 32'h0050_0093);
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("seq_addr", imem_addr, 32'h0000_0004);
    chk("seq_req", {31'd0, imem_req}, 32'd1);

    // Stall in HOLD for 5 cycles with redirect inputs wiggling.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0; pc_sel = 1'b1; alu_target = 32'h0000_0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst, 32'h00A0_0113);
      chk("stall_pc", pc, 32'h0000_0004);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1; alu_target = 32'h0000_0104;
    tick();
    inst_ready = 1'b0; pc_sel = 1'b0;
    chk("redir_addr", imem_addr, 32'h0000_0104);

    // Misaligned redirect.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_rvalid = 1'b0; inst_ready = 1'b1; pc_sel = 1'b1; alu_target = 32'h0000_0106;
    tick();
    inst_ready = 1'b0; pc_sel = 1'b0;
    chk("mis_addr", imem_addr, 32'h0000_0104);
    chk("mis_pulse", {31'd0, misalign}, {31'd0, MIS_EN});
    tick();
    chk("mis_clear", {31'd0, misalign}, 32'd0);

    // Timeout: 8 WAIT cycles without rvalid.
    repeat (7) tick();
    chk("tmo_no_err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_rereq", {31'd0, imem_req}, 32'd1);
    chk("tmo_addr", imem_addr, 32'h0000_0104);
    tick();
    chk("tmo_err_pulse", {31'd0, fetch_err}, 32'd0);
    // rvalid on the 8th WAIT cycle beats the timeout.
    repeat (7) tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("late_no_err", {31'd0, fetch_err}, 32'd0);
    chk("late_inst", inst, 32'h1234_5678);

    // PC wrap-around.
    inst_ready = 1'b1; pc_sel = 1'b1; alu_target = 32'hFFFF_FFFE;
    tick();
    inst_ready = 1'b0; pc_sel = 1'b0;
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    tick();
    imem_rvalid = 1'b0;
    chk("wrap_pc4", pc_four, 32'h0000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset during WAIT; late rvalid after release is ignored.
    inst_ready = 1'b0;
    alu_target = 32'h0000_0200; pc_sel = 1'b1; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; pc_sel = 1'b0;
    tick();
    chk("pre_rst_addr", imem_addr, 32'h0000_0000);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_inst", inst, 32'h0000_0013);
    tick();
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("rst_rereq", {31'd0, imem_req}, 32'd1);
    chk("rst_readdr", imem_addr, 32'h0000_0000);
    imem_rvalid = 1'b0;
    tick();
    chk("rst_ignored", inst, 32'h0000_0013);
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("rst_refetch", inst, 32'h0010_0093);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
